// File: rtl/gb_fs_if.sv
// gb_fs_if: enable/div_bit inputs, tick strobes and step index of the frame sequencer.
// Optional GB_FS_DEBUG_TICK_EN adds a dbg_tick input.
interface gb_fs_if;
    logic       enable;
    logic       div_bit;
    logic       clk_length;
    logic       clk_sweep;
    logic       clk_vol_env;
    logic [2:0] step;
`ifdef GB_FS_DEBUG_TICK_EN
    logic       dbg_tick;
    modport master (output enable, div_bit, dbg_tick, input clk_length, clk_sweep, clk_vol_env, step);
    modport slave  (input enable, div_bit, dbg_tick, output clk_length, clk_sweep, clk_vol_env, step);
`else
    modport master (output enable, div_bit, input clk_length, clk_sweep, clk_vol_env, step);
    modport slave  (input enable, div_bit, output clk_length, clk_sweep, clk_vol_env, step);
`endif
endinterface

// File: rtl/gb_frame_sequencer.sv
// gb_frame_sequencer: 512 Hz APU frame sequencer issuing length/sweep/envelope tick strobes.
// Optional GB_FS_DEBUG_TICK_EN lets dbg_tick force an extra step event.
module gb_frame_sequencer #(
    parameter bit EXT_DIV  = 1'b1,
    parameter int PRESCALE = 8192
) (
    input logic   clk,
    input logic   rst_n,
    gb_fs_if.slave fs
);
    localparam int PW = $clog2(PRESCALE);
    logic          div_bit_q;
    logic [PW-1:0] presc;
    logic          presc_end;
    logic          nat_evt;
    logic          evt;
    assign presc_end = presc == PW'(PRESCALE - 1);
    assign nat_evt   = EXT_DIV ? (div_bit_q && !fs.div_bit) : presc_end;
`ifdef GB_FS_DEBUG_TICK_EN
    assign evt = fs.enable && (nat_evt || fs.dbg_tick);
`else
    assign evt = fs.enable && nat_evt;
`endif
    // evt is already gated by enable, so disabling also silences the strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_bit_q      <= 1'b0;
            presc          <= '0;
            fs.step        <= 3'd0;
            fs.clk_length  <= 1'b0;
            fs.clk_sweep   <= 1'b0;
            fs.clk_vol_env <= 1'b0;
        end else begin
            div_bit_q      <= fs.div_bit;
            presc          <= (!fs.enable || presc_end) ? '0 : presc + 1'b1;
            fs.step        <= !fs.enable ? 3'd0 : fs.step + 3'(evt);
            fs.clk_length  <= evt && !fs.step[0];
            fs.clk_sweep   <= evt && fs.step[1:0] == 2'b10;
            fs.clk_vol_env <= evt && fs.step == 3'd7;
        end
    end
endmodule

// File: tb/tb_gb_frame_sequencer.sv
// tb_gb_frame_sequencer: directed checks of external-DIV and internal-prescaler sequencers.
module tb_gb_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0] el = 8'h55;
    logic [7:0] es = 8'h44;
    logic [7:0] ee = 8'h80;
    int nl, ns, ne, first_l, env_cyc;

    gb_fs_if ext_if ();
    gb_fs_if int_if ();

    gb_frame_sequencer #(.EXT_DIV(1'b1)) u_ext (.clk(clk), .rst_n(rst_n), .fs(ext_if.slave));
    gb_frame_sequencer #(.EXT_DIV(1'b0), .PRESCALE(8)) u_int (.clk(clk), .rst_n(rst_n), .fs(int_if.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ext_str();
        return {ext_if.clk_length, ext_if.clk_sweep, ext_if.clk_vol_env};
    endfunction

    // div_bit high for one edge, then low: the second edge carries the event
    task automatic fall();
        ext_if.div_bit = 1'b1;
        tick();
        chk("quiet_before_fall", 32'(ext_str()), 32'd0);
        ext_if.div_bit = 1'b0;
        tick();
    endtask

    initial begin
        ext_if.enable = 1'b0;
        ext_if.div_bit = 1'b0;
        int_if.enable = 1'b0;
        int_if.div_bit = 1'b0;
`ifdef GB_FS_DEBUG_TICK_EN
        ext_if.dbg_tick = 1'b0;
        int_if.dbg_tick = 1'b0;
`endif
        #12;
        chk("rst_step", 32'(ext_if.step), 32'd0);
        chk("rst_strobes", 32'(ext_str()), 32'd0);
        tick();
        rst_n = 1'b1;
        ext_if.enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            fall();
            chk($sformatf("s1_strobes_%0d", i), 32'(ext_str()), 32'({el[i], es[i], ee[i]}));
            chk($sformatf("s1_step_%0d", i), 32'(ext_if.step), 32'((i + 1) % 8));
        end
        tick();
        chk("s1_width", 32'(ext_str()), 32'd0);

        nl = 0; ns = 0; ne = 0; first_l = 0; env_cyc = 0;
        int_if.enable = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (int_if.clk_length) begin
                nl++;
                if (first_l == 0) first_l = c;
            end
            if (int_if.clk_sweep) ns++;
            if (int_if.clk_vol_env) begin
                ne++;
                env_cyc = c;
            end
        end
        int_if.enable = 1'b0;
        chk("s2_first_len", 32'(first_l), 32'd8);
        chk("s2_len_cnt", 32'(nl), 32'd4);
        chk("s2_sweep_cnt", 32'(ns), 32'd2);
        chk("s2_env_cnt", 32'(ne), 32'd1);
        chk("s2_env_cyc", 32'(env_cyc), 32'd64);

        ext_if.enable = 1'b0;
        ext_if.div_bit = 1'b1;
        tick();
        tick();
        chk("s3_idle_step", 32'(ext_if.step), 32'd0);
        ext_if.enable = 1'b1;
        ext_if.div_bit = 1'b0;
        tick();
        chk("s3_strobes", 32'(ext_str()), 32'b100);
        chk("s3_step", 32'(ext_if.step), 32'd1);
        tick();
        chk("s3_width", 32'(ext_str()), 32'd0);

        repeat (4) fall();
        chk("s4_step5", 32'(ext_if.step), 32'd5);
        ext_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("s4_dis_step_%0d", i), 32'(ext_if.step), 32'd0);
            chk($sformatf("s4_dis_str_%0d", i), 32'(ext_str()), 32'd0);
        end
        ext_if.enable = 1'b1;
        fall();
        chk("s4_reen_strobes", 32'(ext_str()), 32'b100);
        chk("s4_reen_step", 32'(ext_if.step), 32'd1);

        repeat (6) fall();
        chk("s5_step7", 32'(ext_if.step), 32'd7);
        fall();
        chk("s5_env", 32'(ext_str()), 32'b001);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s5_async_env", 32'(ext_str()), 32'd0);
        chk("s5_async_step", 32'(ext_if.step), 32'd0);
        #1;
        rst_n = 1'b1;
        fall();
        chk("s5_post_len", 32'(ext_str()), 32'b100);
        chk("s5_post_step", 32'(ext_if.step), 32'd1);
        repeat (2) fall();
        chk("s5_step3", 32'(ext_if.step), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s5_async_step3", 32'(ext_if.step), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();

`ifdef GB_FS_DEBUG_TICK_EN
        for (int i = 0; i < 8; i++) begin
            ext_if.dbg_tick = 1'b1;
            tick();
            chk($sformatf("dbg_strobes_%0d", i), 32'(ext_str()), 32'({el[i], es[i], ee[i]}));
            chk($sformatf("dbg_step_%0d", i), 32'(ext_if.step), 32'((i + 1) % 8));
            ext_if.dbg_tick = 1'b0;
            tick();
            chk($sformatf("dbg_width_%0d", i), 32'(ext_str()), 32'd0);
        end
        ext_if.div_bit = 1'b1;
        tick();
        ext_if.div_bit = 1'b0;
        ext_if.dbg_tick = 1'b1;
        tick();
        ext_if.dbg_tick = 1'b0;
        chk("dbg_coinc_step", 32'(ext_if.step), 32'd1);
        tick();
        chk("dbg_coinc_hold", 32'(ext_if.step), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gb_frame_sequencer.md
Name: gb_frame_sequencer

Overview:
- Generates the 512 Hz frame-sequencer timing for the APU channel blocks.
- Issues single-cycle tick strobes:
  - clk_length to the length counters.
  - clk_sweep to the channel-1 frequency sweep.
  - clk_vol_env to every envelope function, which consumes these ticks together with its channel trigger.
- Sits between the DIV/timer logic and the per-channel modulation units.

Parameters:
- EXT_DIV, 1: 1 = step on falling edge of div_bit input; 0 = step from internal prescaler.
- PRESCALE, 8192: clk cycles per step when EXT_DIV=0 (4.194304 MHz / 512); must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  APU power (NR52 bit 7); 0 holds the sequencer idle
- div_bit  input  1  DIV counter bit (bit 4 of DIV, i.e. 512 Hz square); used only when EXT_DIV=1
- clk_length  output  1  one-cycle strobe, length-counter tick (256 Hz)
- clk_sweep  output  1  one-cycle strobe, sweep tick (128 Hz)
- clk_vol_env  output  1  one-cycle strobe, envelope tick (64 Hz)
- step  output  3  index of the next step to execute

Behaviour:
- Reset (rst_n low, asynchronous):
  - step=0; clk_length=clk_sweep=clk_vol_env=0.
  - Prescaler=0; div_bit_q=0.
- div_bit_q:
  - Registers div_bit every clk edge, including while enable=0.
  - Prevents a false edge on enable.
- Step event, computed from current-cycle values:
  - EXT_DIV=1: enable && div_bit_q && !div_bit (falling edge).
  - EXT_DIV=0: enable && prescaler==PRESCALE-1.
  - Prescaler width: $clog2(PRESCALE).
  - Prescaler counts 0..PRESCALE-1 while enable=1, then wraps to 0 on the event edge.
- On the clk edge where an event is true, with s = current step:
  - clk_length <= (s[0]==0), i.e. steps 0,2,4,6.
  - clk_sweep <= (s==2 || s==6).
  - clk_vol_env <= (s==7).
  - step <= s+1, wrapping 7 -> 0.
- Strobe timing:
  - Strobes are registered.
  - Each is high for exactly one cycle, following the event edge.
  - Strobes are 0 on all other cycles.
- Latency: falling div_bit sampled at edge N -> strobe high during cycle N..N+1.
- enable=0:
  - step forced to 0; prescaler forced to 0; strobes forced to 0 on next edge.
  - No events.
- enable 0->1:
  - Sequencer starts at step 0.
  - First event executes step 0 (length tick only).
  - With EXT_DIV=0, the first event comes PRESCALE cycles after the enable edge.
- enable falling in the same cycle as a would-be event: disable wins; no strobe; step -> 0.
- Events arrive at most once per PRESCALE cycles (internal), or once per div_bit period (external). No back-to-back event handling required.
- rst_n asserted mid-sequence: immediate clear to reset values, including any strobe in flight.
- Full 8-step cycle: 4 length, 2 sweep, 1 envelope strobe; step 1, 3, 5 produce no strobe.

Optional Feature:
- Macro: GB_FS_DEBUG_TICK_EN.
- When defined:
  - Adds input dbg_tick (1 bit).
  - A cycle with enable && dbg_tick is treated as a step event, OR'd with the normal event.
  - Simultaneous dbg_tick and normal event count as one event, not two.
  - Used by benches to advance steps without waiting 8192 cycles.
- When undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset then enable=1, EXT_DIV=1, drive 8 falling edges of div_bit -> strobes in order:
  - L, -, L+S, -, L, -, L+S, E.
  - step sequence 1,2,...,7,0.
  - Each strobe exactly 1 cycle wide.
- EXT_DIV=0, PRESCALE=8 (bench override), enable=1 for 64 cycles:
  - First clk_length 8 cycles after enable.
  - clk_vol_env exactly once, at cycle 64.
  - clk_length count=4; clk_sweep count=2.
- div_bit held high, then enable 0->1 with div_bit dropping in the same cycle:
  - div_bit_q already high, so step 0 fires.
  - clk_length pulses once; step=1.
- Advance to step=5, drop enable for 3 cycles, re-enable, give one edge:
  - step reads 0 while disabled.
  - clk_length fires (step 0); clk_vol_env does not.
- At step=7, assert rst_n=0 asynchronously in the cycle clk_vol_env is high:
  - clk_vol_env and step clear immediately without waiting for clk.
  - After release, the next edge produces clk_length.
- With GB_FS_DEBUG_TICK_EN, pulse dbg_tick 8 times at 2-cycle spacing -> same strobe pattern as scenario 1.
- With GB_FS_DEBUG_TICK_EN, dbg_tick coincident with a div_bit fall -> step advances by 1 only.
